// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: memory-mapped UART peripheral with TX/RX FIFOs, status/control
// registers, sticky error flags, internal loopback and a registered level interrupt.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   uart_rxd/txd      serial receive / transmit pins
//   uart_addr         byte address, [3:2] selects DATA/STATUS/CTRL/LED
//   uart_write_data   CPU write data, qualified by uart_wen
//   uart_ren          read strobe; uart_read_data is valid the following cycle
//   led               LED register
//   irq               level interrupt (RX not empty / TX drained)
//
// Also contains the helper modules uart_fifo_periph_fifo, uart_tx and uart_rx.

// Synchronous FIFO, binary pointers, occupancy count drives full/empty.
// Push while full succeeds only if a pop happens in the same cycle.
module uart_fifo_periph_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head     = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// UART transmitter: 8N1-style frame (start, PAYLOAD_BITS LSB first, stop).
// busy is high from the cycle after uart_tx_en is accepted to the end of the stop bit.
module uart_tx #(
  parameter int unsigned CLK_HZ       = 10_000_000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
  localparam int unsigned CPB = CLK_HZ / BIT_RATE;
  localparam int unsigned CW  = $clog2(CPB) + 1;
  localparam int unsigned BW  = $clog2(PAYLOAD_BITS + 2) + 1;

  logic                  txd_q, txd_d, busy_q, busy_d;
  logic [PAYLOAD_BITS:0] sr_q, sr_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BW-1:0]         left_q, left_d;

  always_comb begin
    txd_d  = txd_q;
    busy_d = busy_q;
    sr_d   = sr_q;
    cyc_d  = cyc_q;
    left_d = left_q;
    if (!busy_q) begin
      txd_d = 1'b1;
      if (uart_tx_en) begin
        busy_d = 1'b1;
        txd_d  = 1'b0;
        sr_d   = {1'b1, uart_tx_data};
        left_d = BW'(PAYLOAD_BITS + 1);
        cyc_d  = CW'(CPB - 1);
      end
    end else if (cyc_q != '0) begin
      cyc_d = cyc_q - CW'(1);
    end else if (left_q == '0) begin
      busy_d = 1'b0;
      txd_d  = 1'b1;
    end else begin
      txd_d  = sr_q[0];
      sr_d   = {1'b0, sr_q[PAYLOAD_BITS:1]};
      left_d = left_q - BW'(1);
      cyc_d  = CW'(CPB - 1);
    end
    uart_txd     = txd_q;
    uart_tx_busy = busy_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
      sr_q   <= '0;
      cyc_q  <= '0;
      left_q <= '0;
    end else begin
      txd_q  <= txd_d;
      busy_q <= busy_d;
      sr_q   <= sr_d;
      cyc_q  <= cyc_d;
      left_q <= left_d;
    end
  end
endmodule

// UART receiver: samples mid-bit after a two-flop synchroniser. A frame with a low
// stop bit and all-zero data is a break; any low stop bit waits for the line to idle.
module uart_rx #(
  parameter int unsigned CLK_HZ       = 10_000_000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
  localparam int unsigned CPB = CLK_HZ / BIT_RATE;
  localparam int unsigned CW  = $clog2(CPB) + 1;
  localparam int unsigned IW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t               state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] sh_q, sh_d;
  logic                    valid_q, valid_d, brk_q, brk_d, rxs;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], uart_rxd};
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    brk_d   = 1'b0;
    rxs     = sync_q[1];
    case (state_q)
      RX_IDLE: if (!rxs) begin
        state_d = RX_START;
        cyc_d   = CW'(CPB / 2 - 1);
      end
      RX_START: if (cyc_q != '0) cyc_d = cyc_q - CW'(1);
        else if (!rxs) begin
          state_d = RX_DATA;
          cyc_d   = CW'(CPB - 1);
          idx_d   = '0;
        end else state_d = RX_IDLE;
      RX_DATA: if (cyc_q != '0) cyc_d = cyc_q - CW'(1);
        else begin
          sh_d  = {rxs, sh_q[PAYLOAD_BITS-1:1]};
          cyc_d = CW'(CPB - 1);
          if (idx_q == IW'(PAYLOAD_BITS - 1)) state_d = RX_STOP;
          else idx_d = idx_q + IW'(1);
        end
      RX_STOP: if (cyc_q != '0) cyc_d = cyc_q - CW'(1);
        else if (rxs) begin
          valid_d = 1'b1;
          state_d = RX_IDLE;
        end else begin
          brk_d   = (sh_q == '0);
          state_d = RX_WAIT;
        end
      RX_WAIT: if (rxs) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
    uart_rx_valid = valid_q;
    uart_rx_break = brk_q;
    uart_rx_data  = sh_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      cyc_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
    end
  end
endmodule

module uart_fifo_periph #(
  parameter int unsigned CLK_HZ       = 10_000_000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned RX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_write_data,
  input  logic        uart_wen,
  input  logic        uart_ren,
  output logic [31:0] uart_read_data,
  output logic [7:0]  led,
  output logic        irq
);
  localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXCW = $clog2(RX_DEPTH) + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY} tx_state_t;

  tx_state_t               tx_state_q, tx_state_d;
  logic [4:0]              ctrl_q, ctrl_d;
  logic [7:0]              led_q, led_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    irq_q, irq_d;
  logic                    rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d, brk_q, brk_d;

  logic [1:0]              sel;
  logic                    wr, rd, tx_push, tx_pop, rx_push, rx_pop;
  logic                    tx_full, tx_empty, rx_full, rx_empty, tx_active;
  logic [TXCW-1:0]         tx_count;
  logic [RXCW-1:0]         rx_count;
  logic [PAYLOAD_BITS-1:0] tx_head, rx_head, urx_data;
  logic                    utx_en, utx_busy, utx_serial, urx_valid, urx_break, rx_in;
  logic [31:0]             status;
  logic                    unused_bits;

  uart_fifo_periph_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(uart_write_data[PAYLOAD_BITS-1:0]), .head(tx_head), .count(tx_count)
  );

  uart_fifo_periph_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(urx_data), .head(rx_head), .count(rx_count)
  );

  uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_tx (
    .clk(clk), .resetn(~rst), .uart_txd(utx_serial), .uart_tx_busy(utx_busy),
    .uart_tx_en(utx_en), .uart_tx_data(tx_head)
  );

  uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_rx (
    .clk(clk), .resetn(~rst), .uart_rxd(rx_in), .uart_rx_break(urx_break),
    .uart_rx_valid(urx_valid), .uart_rx_data(urx_data)
  );

  always_comb begin
    unused_bits = ^{uart_addr[31:4], uart_addr[1:0], uart_write_data[31:8]};
    sel         = uart_addr[3:2];
    wr          = uart_wen;
    rd          = uart_ren && !uart_wen;
    tx_full     = (tx_count == TXCW'(TX_DEPTH));
    tx_empty    = (tx_count == '0);
    rx_full     = (rx_count == RXCW'(RX_DEPTH));
    rx_empty    = (rx_count == '0);
    tx_active   = (tx_state_q != TX_IDLE);
    rx_in       = ctrl_q[2] ? utx_serial : uart_rxd;
    uart_txd    = ctrl_q[2] ? 1'b1 : utx_serial;
    tx_push     = wr && (sel == 2'd0) && !tx_full;
    rx_pop      = rd && (sel == 2'd0) && !rx_empty;
    rx_push     = urx_valid && ctrl_q[0];

    status              = '0;
    status[0]           = !rx_empty;
    status[1]           = rx_full;
    status[2]           = tx_empty;
    status[3]           = tx_full;
    status[4]           = rx_ovr_q;
    status[5]           = tx_ovf_q;
    status[6]           = brk_q;
    status[7]           = tx_active;
    status[8 +: RXCW]   = rx_count;
    status[16 +: TXCW]  = tx_count;

    // TX drain FSM: the pop and the uart_tx start strobe are the same cycle
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    utx_en     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (ctrl_q[1] && !tx_empty && !utx_busy) begin
        tx_pop     = 1'b1;
        utx_en     = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START:     tx_state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (!utx_busy) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase

    rdata_d = '0;
    if (rd) begin
      case (sel)
        2'd0:    rdata_d = 32'(rx_head) & {32{!rx_empty}};
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = {27'b0, ctrl_q};
        default: rdata_d = {24'b0, led_q};
      endcase
    end

    ctrl_d = ctrl_q;
    if (wr && sel == 2'd2) ctrl_d = uart_write_data[4:0];

    led_d = led_q;
    if (urx_valid) led_d = 8'(urx_data);
    if (wr && sel == 2'd3) led_d = uart_write_data[7:0];

    // Sticky flags: a new event in the same cycle as a W1C wins
    rx_ovr_d = rx_ovr_q;
    tx_ovf_d = tx_ovf_q;
    brk_d    = brk_q;
    if (wr && sel == 2'd1) begin
      if (uart_write_data[4]) rx_ovr_d = 1'b0;
      if (uart_write_data[5]) tx_ovf_d = 1'b0;
      if (uart_write_data[6]) brk_d    = 1'b0;
    end
    if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    if (wr && sel == 2'd0 && tx_full)   tx_ovf_d = 1'b1;
    if (urx_break)                      brk_d    = 1'b1;

    irq_d = (ctrl_q[3] && !rx_empty) || (ctrl_q[4] && tx_empty && !tx_active);

    uart_read_data = rdata_q;
    led            = led_q;
    irq            = irq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      ctrl_q     <= 5'b00011;
      led_q      <= 8'hF0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      ctrl_q     <= ctrl_d;
      led_q      <= led_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovf_q   <= tx_ovf_d;
      brk_q      <= brk_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// Testbench for uart_fifo_periph: directed sequence with random payloads, checked
// against a queue-based model of the FIFOs, sticky flags and LED register.
module tb_uart_fifo_periph;
  localparam int unsigned CPB = 16;
  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_LED = 32'hC;

  logic        clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1;
  logic        uart_wen = 1'b0, uart_ren = 1'b0;
  logic [31:0] uart_addr = '0, uart_write_data = '0;
  logic        uart_txd, irq;
  logic [31:0] uart_read_data;
  logic [7:0]  led;

  int          checks = 0, errors = 0;
  int unsigned cyc_cnt = 0;

  logic [7:0]  mtxq[$], mrxq[$];
  logic        movr = 1'b0, movf = 1'b0, mbrk = 1'b0;
  logic [7:0]  mled = 8'hF0;

  logic [7:0]  seen_b[$];
  int unsigned seen_t[$];
  int          stop_err = 0;

  uart_fifo_periph #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8),
                     .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .uart_addr(uart_addr), .uart_write_data(uart_write_data),
    .uart_wen(uart_wen), .uart_ren(uart_ren), .uart_read_data(uart_read_data),
    .led(led), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Serial line monitor: decodes every frame on uart_txd
  initial begin
    logic [7:0]  b;
    int unsigned t0;
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        t0 = cyc_cnt;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (uart_txd !== 1'b1) stop_err++;
        seen_b.push_back(b);
        seen_t.push_back(t0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (mrxq.size() != 0);
    s[1]    = (mrxq.size() == 16);
    s[2]    = (mtxq.size() == 0);
    s[3]    = (mtxq.size() == 16);
    s[4]    = movr;
    s[5]    = movf;
    s[6]    = mbrk;
    s[15:8] = 8'(mrxq.size());
    s[23:16] = 8'(mtxq.size());
    return s;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    uart_addr = a; uart_write_data = d; uart_wen = 1'b1;
    @(negedge clk);
    uart_wen = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    uart_addr = a; uart_ren = 1'b1;
    @(negedge clk);
    uart_ren = 1'b0;
    check(tag, uart_read_data, exp);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    bus_write(A_DATA, {24'h0, b});
    if (mtxq.size() < 16) mtxq.push_back(b);
    else movf = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (CPB + 2) @(negedge clk);
    if (mrxq.size() < 16) mrxq.push_back(b);
    else movr = 1'b1;
    mled = b;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (seen_b.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_frames_arrived", 32'(seen_b.size() >= n), 32'd1);
  endtask

  task automatic compare_frames(input int n);
    for (int i = 0; i < n; i++)
      check("tx_frame_byte", {24'h0, seen_b[i]}, {24'h0, mtxq.pop_front()});
    check("tx_stop_bits", stop_err, 0);
  endtask

  initial begin
    logic [31:0] rexp;
    int          g, low_seen;
    logic [7:0]  r;

    // 1: reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_txd", {31'h0, uart_txd}, 32'd1);
    check("rst_led", {24'h0, led}, 32'hF0);
    check("rst_irq", {31'h0, irq}, 32'd0);
    check("rst_rdata", uart_read_data, 32'h0);
    read_check("rst_status", A_STAT, 32'h0000_0004);
    read_check("rst_ctrl", A_CTRL, 32'h3);
    read_check("rst_led_reg", A_LED, 32'hF0);
    read_check("rst_data_empty", A_DATA, 32'h0);
    check("rdata_returns_zero", uart_read_data, 32'h0);

    // 2: back-to-back burst
    for (int i = 0; i < 4; i++) tx_byte(8'h41 + 8'(i));
    wait_frames(4, 50 * CPB);
    for (int i = 1; i < 4; i++) begin
      g = int'(seen_t[i] - seen_t[i-1]);
      check("tx_frame_spacing", 32'(g >= 10 * CPB && g <= 11 * CPB), 32'd1);
    end
    compare_frames(4);
    repeat (2 * CPB) @(negedge clk);
    read_check("burst_status_drained", A_STAT, exp_status());

    // 3: TX overflow with TX disabled, then drain
    bus_write(A_CTRL, 32'h01);
    for (int i = 0; i < 17; i++) tx_byte(8'($urandom));
    read_check("txovf_status", A_STAT, exp_status());
    bus_write(A_STAT, 32'h20);
    movf = 1'b0;
    read_check("txovf_w1c", A_STAT, exp_status());
    seen_b.delete();
    seen_t.delete();
    bus_write(A_CTRL, 32'h03);
    wait_frames(16, 16 * 12 * CPB);
    compare_frames(16);
    repeat (2 * CPB) @(negedge clk);
    read_check("txovf_drained", A_STAT, exp_status());
    bus_write(A_CTRL, 32'h13);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", {31'h0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h03);
    repeat (2) @(negedge clk);
    check("irq_tx_masked", {31'h0, irq}, 32'd0);

    // 4: RX overrun
    for (int i = 0; i <= 16; i++) send_rx(8'(i));
    read_check("rxovr_status", A_STAT, exp_status());
    check("rx_led_copy", {24'h0, led}, {24'h0, mled});
    for (int i = 0; i < 17; i++) begin
      rexp = (mrxq.size() != 0) ? {24'h0, mrxq.pop_front()} : 32'h0;
      read_check("rx_data_pop", A_DATA, rexp);
    end
    read_check("rx_drained_status", A_STAT, exp_status());
    bus_write(A_STAT, 32'h10);
    movr = 1'b0;
    read_check("rxovr_w1c", A_STAT, exp_status());

    // random RX bytes
    for (int i = 0; i < 3; i++) send_rx(8'($urandom));
    read_check("rx_rand_status", A_STAT, exp_status());
    for (int i = 0; i < 3; i++) read_check("rx_rand_data", A_DATA, {24'h0, mrxq.pop_front()});

    // break condition
    uart_rxd = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    mbrk = 1'b1;
    read_check("brk_status", A_STAT, exp_status());
    bus_write(A_STAT, 32'h40);
    mbrk = 1'b0;
    read_check("brk_w1c", A_STAT, exp_status());

    // 5: loopback
    bus_write(A_CTRL, 32'h0F);
    low_seen = 0;
    tx_byte(8'h5A);
    void'(mtxq.pop_front());
    mrxq.push_back(8'h5A);
    mled = 8'h5A;
    for (int k = 0; k < 12 * CPB; k++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) low_seen++;
      if (irq === 1'b1) break;
    end
    check("loop_irq", {31'h0, irq}, 32'd1);
    repeat (CPB) @(negedge clk);
    read_check("loop_status", A_STAT, exp_status());
    read_check("loop_data", A_DATA, {24'h0, mrxq.pop_front()});
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      tx_byte(r);
      void'(mtxq.pop_front());
      mrxq.push_back(r);
      mled = r;
    end
    for (int k = 0; k < 36 * CPB; k++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) low_seen++;
    end
    check("loop_txd_idle", low_seen, 0);
    read_check("loop_rand_status", A_STAT, exp_status());
    for (int i = 0; i < 3; i++) read_check("loop_rand_data", A_DATA, {24'h0, mrxq.pop_front()});
    read_check("loop_led", A_LED, {24'h0, mled});
    read_check("loop_ctrl", A_CTRL, 32'h0F);
    repeat (2) @(negedge clk);
    check("loop_irq_clear", {31'h0, irq}, 32'd0);

    // simultaneous write and read: write wins, no read data
    uart_addr = A_LED; uart_write_data = 32'h3C; uart_wen = 1'b1; uart_ren = 1'b1;
    @(negedge clk);
    uart_wen = 1'b0; uart_ren = 1'b0;
    mled = 8'h3C;
    check("wr_rd_same_cycle_rdata", uart_read_data, 32'h0);
    check("wr_rd_same_cycle_led", {24'h0, led}, {24'h0, mled});

    // 6: reset during bit 3 of 0xA5
    bus_write(A_CTRL, 32'h03);
    tx_byte(8'hA5);
    for (int k = 0; k < 4 * CPB && uart_txd !== 1'b0; k++) @(negedge clk);
    check("rst_tx_started", {31'h0, uart_txd}, 32'd0);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("rst_tx_bit3_low", {31'h0, uart_txd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mtxq.delete(); mrxq.delete();
    movr = 1'b0; movf = 1'b0; mbrk = 1'b0; mled = 8'hF0;
    check("rst_mid_txd", {31'h0, uart_txd}, 32'd1);
    read_check("rst_mid_status", A_STAT, exp_status());
    read_check("rst_mid_led", A_LED, 32'hF0);
    repeat (2 * CPB) @(negedge clk);
    check("rst_mid_txd_idle", {31'h0, uart_txd}, 32'd1);
    read_check("rst_mid_status_later", A_STAT, exp_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
